// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the memory stage.
package riscv_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Writeback select carried through to MEM/WB.
    localparam logic OP_TYPE_ALU = 1'b0;
    localparam logic OP_TYPE_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load lane extraction / sign extension and store byte-enable / lane replication.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    // Store side: enable the addressed lanes and replicate the data across the word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {st_addr_lo[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        byte_sh = ld_word >> {ld_addr_lo, 3'b000};
        half_sh = ld_word >> {ld_addr_lo[1], 4'b0000};
        case (ld_funct3)
            FUNCT3_LB:  ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            FUNCT3_LBU: ld_data = {24'b0, byte_sh[7:0]};
            FUNCT3_LH:  ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
            FUNCT3_LHU: ld_data = {16'b0, half_sh[15:0]};
            default:    ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack data-memory handshake, timeout abort,
// load/store alignment and MEM/WB pass-through.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no transfer open; aligned mem op latches request and stalls
//  REQ   | request on the bus, waiting for ack or timeout
//  DONE  | result presented to MEM/WB for one cycle, stall released
module mem_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_rs2_val,
    input  logic [4:0]  i_rd_num,
    input  logic        i_op_type,
    input  logic [31:0] i_debug_pc,
    input  logic [31:0] i_debug_inst,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic [31:0] o_mem_out,
    output logic [31:0] o_alu_out,
    output logic [4:0]  o_rd_num,
    output logic        o_op_type,
    output logic [31:0] o_debug_pc,
    output logic [31:0] o_debug_inst
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [31:0]       buf_q;
    logic              bus_err_q;

    logic              mem_op;
    logic              misaligned;
    logic              start;
    logic              timeout;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;

    assign mem_op     = i_valid & (i_mem_read | i_mem_write);
    assign misaligned = mem_op & is_misaligned(i_funct3, i_alu_out[1:0]);
    assign start      = mem_op & ~misaligned;
    assign timeout    = (cnt_q == CNT_LAST) & ~i_dmem_ack;

    lsu_align u_align (
        .st_funct3  (i_funct3),
        .st_addr_lo (i_alu_out[1:0]),
        .st_data    (i_rs2_val),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_funct3  (funct3_q),
        .ld_addr_lo (addr_q[1:0]),
        .ld_word    (buf_q),
        .ld_data    (ld_data)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; ack beats a coincident timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (i_dmem_ack || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, timeout counter, load buffer and bus-error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            funct3_q  <= '0;
            buf_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        addr_q   <= i_alu_out;
                        wdata_q  <= st_wdata;
                        be_q     <= st_be;
                        we_q     <= i_mem_write;
                        funct3_q <= i_funct3;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (i_dmem_ack) begin
                        buf_q <= i_dmem_rdata;
                    end else if (timeout) begin
                        buf_q     <= '0;
                        bus_err_q <= 1'b1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // Outputs: stall, bus request and MEM/WB payload.
    always_comb begin
        o_dmem_req   = (state == REQ);
        o_dmem_we    = we_q;
        o_dmem_addr  = {addr_q[31:2], 2'b00};
        o_dmem_wdata = wdata_q;
        o_dmem_be    = be_q;
        o_bus_err    = bus_err_q;
        o_misaligned = misaligned;
        o_stall      = ~i_rst & (((state == IDLE) & start) | (state == REQ));
        o_mem_out    = (~i_rst & (state == DONE)) ? ld_data : 32'b0;
        o_rd_num     = i_rd_num;
        if (i_rst || misaligned || ((state == DONE) && bus_err_q)) o_rd_num = 5'd0;
        o_alu_out    = i_alu_out;
        o_op_type    = i_op_type;
        o_debug_pc   = i_debug_pc;
        o_debug_inst = i_debug_inst;
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, mem_read, mem_write, op_type, dmem_ack;
    logic [2:0]  funct3;
    logic [31:0] alu_in, rs2_val, debug_pc, debug_inst, dmem_rdata;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we, stall, misaligned, bus_err, op_type_o;
    logic [31:0] dmem_addr, dmem_wdata, mem_out, alu_o, debug_pc_o, debug_inst_o;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_mem_read(mem_read),
        .i_mem_write(mem_write), .i_funct3(funct3), .i_alu_out(alu_in),
        .i_rs2_val(rs2_val), .i_rd_num(rd_in), .i_op_type(op_type),
        .i_debug_pc(debug_pc), .i_debug_inst(debug_inst),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be), .i_dmem_ack(dmem_ack),
        .i_dmem_rdata(dmem_rdata), .o_stall(stall), .o_misaligned(misaligned),
        .o_bus_err(bus_err), .o_mem_out(mem_out), .o_alu_out(alu_o),
        .o_rd_num(rd_o), .o_op_type(op_type_o), .o_debug_pc(debug_pc_o),
        .o_debug_inst(debug_inst_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: access size in bytes from the width code.
    function automatic int ref_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * (a % 4)));
        h = 16'(w >> (16 * ((a % 4) / 2)));
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b100:  return 32'(b);
            3'b001:  return 32'($signed(h));
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = ref_size(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return 32'(d[7:0]) * 32'h0101_0101;
            2'b01:   return 32'(d[15:0]) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    task automatic pass_through(input logic v, input logic [31:0] a, input logic [4:0] rdn);
        valid      = v;
        mem_read   = v ? 1'b0 : 1'($urandom);
        mem_write  = v ? 1'b0 : 1'($urandom);
        funct3     = 3'($urandom);
        alu_in     = a;
        rs2_val    = $urandom;
        rd_in      = rdn;
        op_type    = 1'($urandom);
        debug_pc   = $urandom;
        debug_inst = $urandom;
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
        #1;
        chk("pt_alu", alu_o, a);
        chk("pt_rd", 32'(rd_o), 32'(rdn));
        chk("pt_op", 32'(op_type_o), 32'(op_type));
        chk("pt_pc", debug_pc_o, debug_pc);
        chk("pt_inst", debug_inst_o, debug_inst);
        chk("pt_stall", 32'(stall), 0);
        chk("pt_req", 32'(dmem_req), 0);
        chk("pt_memout", mem_out, 0);
        chk("pt_mis", 32'(misaligned), 0);
        tick();
        dmem_ack = 1'b0;
        chk("pt_req_after", 32'(dmem_req), 0);
    endtask

    // ack_dly: REQ cycle index on which ack arrives; >= TO means never.
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rs2, input int ack_dly,
                          input logic [31:0] rdata, input logic [4:0] rdn);
        logic timed_out;
        valid      = 1'b1;
        mem_read   = ~wr | 1'($urandom);
        mem_write  = wr;
        funct3     = f3;
        alu_in     = a;
        rs2_val    = rs2;
        rd_in      = rdn;
        op_type    = 1'b1;
        debug_pc   = $urandom;
        debug_inst = $urandom;
        #1;
        if ((a % ref_size(f3)) != 0) begin
            chk("mis_flag", 32'(misaligned), 1);
            chk("mis_stall", 32'(stall), 0);
            chk("mis_req", 32'(dmem_req), 0);
            chk("mis_rd", 32'(rd_o), 0);
            chk("mis_memout", mem_out, 0);
            tick();
            chk("mis_req_after", 32'(dmem_req), 0);
            return;
        end
        chk("idle_stall", 32'(stall), 1);
        chk("idle_req", 32'(dmem_req), 0);
        chk("idle_mis", 32'(misaligned), 0);
        chk("idle_buserr", 32'(bus_err), 0);
        tick();
        timed_out = 1'b1;
        for (int k = 0; k < TO; k++) begin
            chk("req_req", 32'(dmem_req), 1);
            chk("req_stall", 32'(stall), 1);
            chk("req_we", 32'(dmem_we), 32'(wr));
            chk("req_addr", dmem_addr, a & ~32'h3);
            if (wr) begin
                chk("req_be", 32'(dmem_be), 32'(ref_be(f3, a)));
                chk("req_wdata", dmem_wdata, ref_wdata(f3, rs2));
            end
            if (k == ack_dly) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
                tick();
                dmem_ack   = 1'b0;
                dmem_rdata = $urandom;
                timed_out  = 1'b0;
                break;
            end
            tick();
        end
        chk("done_req", 32'(dmem_req), 0);
        chk("done_stall", 32'(stall), 0);
        chk("done_buserr", 32'(bus_err), 32'(timed_out));
        chk("done_memout", mem_out, timed_out ? 32'h0 : ref_load(f3, a, rdata));
        chk("done_rd", 32'(rd_o), timed_out ? 32'h0 : 32'(rdn));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        alu_in = 32'h0; rs2_val = 32'h0; rd_in = 5'd7; op_type = 1'b0;
        debug_pc = 32'h0; debug_inst = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        tick(); tick();
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_rd", 32'(rd_o), 0);
        chk("rst_buserr", 32'(bus_err), 0);
        chk("rst_memout", mem_out, 0);
        rst = 1'b0;
        tick();

        pass_through(1'b1, 32'h1234, 5'd5);
        access(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000, 5'd9);   // LB
        access(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0000, 5'd9);   // LBU
        access(1'b1, 3'b001, 32'h202, 32'hABCD_1234, 2, 32'h0, 5'd3);   // SH
        access(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 5'd4);           // LW misaligned
        access(1'b0, 3'b010, 32'h100, 32'h0, TO, 32'h0, 5'd6);          // LW timeout
        access(1'b0, 3'b001, 32'h106, 32'h0, TO - 1, 32'h8765_4321, 5'd8); // ack on last cycle
        access(1'b0, 3'b010, 32'h200, 32'h0, 0, 32'hDEAD_BEEF, 5'd10);

        // Reset while a request is open.
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_in = 32'h300; rd_in = 5'd11;
        tick();
        chk("rstreq_pre", 32'(dmem_req), 1);
        rst = 1'b1;
        #1;
        chk("rstreq_stall", 32'(stall), 0);
        chk("rstreq_rd", 32'(rd_o), 0);
        tick();
        chk("rstreq_req", 32'(dmem_req), 0);
        valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("rstreq_idle", 32'(dmem_req), 0);
        chk("rstreq_memout", mem_out, 0);

        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [2:0] f3;
            logic wr;
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                pass_through(1'($urandom), $urandom, 5'($urandom));
            end else begin
                wr = 1'($urandom);
                if (wr) f3 = 3'($urandom_range(0, 2));
                else begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b010;
                        3: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                end
                access(wr, f3, $urandom, $urandom, int'($urandom_range(0, TO)),
                       $urandom, 5'($urandom_range(1, 31)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
